// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    function automatic int unsigned addr_width(input int unsigned nreg);
        return $clog2(nreg);
    endfunction

    localparam int unsigned AW_DEF = addr_width(NREG_DEF);

    typedef struct packed {
        logic                en;
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
        logic                clr;
    } wr_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bit per register with flush > issue > clear
// priority, and an incrementally maintained busy population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NWR  = 1,
    parameter int unsigned AW   = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR-1:0]    wr_clr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NREG-1:0]   busy,
    output logic [AW:0]       busy_cnt
);

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     inc;
    logic [AW:0]     dec;
    logic [AW:0]     cnt_nxt;

    // Register 0 is never set or cleared, so its busy bit stays 0.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            set_vec[r] = iss_valid && (iss_rd == AW'(r));
            for (int unsigned j = 0; j < NWR; j++) begin
                clr_vec[r] = clr_vec[r] |
                    (wr_en[j] && wr_clr[j] && (wr_addr[j*AW +: AW] == AW'(r)));
            end
        end
    end

    always_comb begin
        if (flush) begin
            busy_nxt = '0;
        end else begin
            busy_nxt = (busy | set_vec) & ~(clr_vec & ~set_vec);
        end
    end

    // Only real transitions move the count, so redundant sets/clears are free.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (busy_nxt[r] && !busy[r]) inc = inc + {{AW{1'b0}}, 1'b1};
            if (!busy_nxt[r] && busy[r]) dec = dec + {{AW{1'b0}}, 1'b1};
        end
        cnt_nxt = flush ? '0 : (busy_cnt + inc - dec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 1,
    parameter int unsigned AW   = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_clr,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_clr    (wr_clr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    // Ascending port order lets the highest-numbered port win on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        if (wr_clr[j]) rd_busy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule
